// File: rtl/udp_recv.sv
// udp_recv: byte-wide GMII receiver for Ethernet/IPv4/UDP frames.
// Filters the headers, streams the UDP payload and reports a CRC32 verdict at end of frame.
module udp_recv (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_data,
    input  logic        i_rx_dv,
    input  logic [47:0] i_my_mac,
    input  logic [31:0] i_my_ip,
    input  logic [15:0] i_my_port,
    output logic [7:0]  o_data,
    output logic        o_data_vl,
    output logic [47:0] o_src_mac,
    output logic [31:0] o_src_ip,
    output logic [15:0] o_src_port,
    output logic [15:0] o_data_len,
    output logic        o_pkt_done,
    output logic        o_pkt_ok
);
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [15:0] MIN_UDP_LEN = 16'd8;
    localparam logic [15:0] MAX_UDP_LEN = 16'd1480;

    typedef enum logic [3:0] {
        IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TAIL, DROP, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [39:0] sh_q, sh_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] csum_q, csum_d;
    logic        bad_q, bad_d;
    logic [47:0] mac_q, mac_d;
    logic [31:0] ip_q, ip_d;
    logic [15:0] port_q, port_d;
    logic [15:0] len_q, len_d;

    logic [7:0]  o_data_q, o_data_d;
    logic        o_data_vl_q, o_data_vl_d;
    logic [47:0] o_src_mac_q, o_src_mac_d;
    logic [31:0] o_src_ip_q, o_src_ip_d;
    logic [15:0] o_src_port_q, o_src_port_d;
    logic [15:0] o_data_len_q, o_data_len_d;
    logic        o_pkt_done_q, o_pkt_done_d;
    logic        o_pkt_ok_q, o_pkt_ok_d;

    logic [47:0] win;
    logic [10:0] cnt_inc;
    logic [16:0] csum_add;
    logic [15:0] csum_fold;
    logic [31:0] crc_upd;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Sliding window of the most recent header bytes, newest byte in [7:0].
    assign win       = {sh_q, i_data};
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 11'd1;
    assign csum_add  = {1'b0, csum_q} + {1'b0, win[15:0]};
    assign csum_fold = csum_add[15:0] + {15'h0, csum_add[16]};
    assign crc_upd   = crc_byte(crc_q, i_data);

    always_comb begin
        state_d      = state_q;
        cnt_d        = i_rx_dv ? cnt_inc : cnt_q;
        sh_d         = i_rx_dv ? win[39:0] : sh_q;
        crc_d        = crc_q;
        csum_d       = csum_q;
        bad_d        = bad_q;
        mac_d        = mac_q;
        ip_d         = ip_q;
        port_d       = port_q;
        len_d        = len_q;
        o_data_d     = o_data_q;
        o_data_vl_d  = 1'b0;
        o_src_mac_d  = o_src_mac_q;
        o_src_ip_d   = o_src_ip_q;
        o_src_port_d = o_src_port_q;
        o_data_len_d = o_data_len_q;
        o_pkt_done_d = 1'b0;
        o_pkt_ok_d   = o_pkt_ok_q;

        unique case (state_q)
            IDLE: begin
                crc_d = CRC_INIT;
                if (i_rx_dv) state_d = (i_data == 8'h55) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                crc_d = CRC_INIT;
                if (!i_rx_dv) begin
                    state_d = IDLE;
                end else if (i_data == 8'hD5) begin
                    state_d = ETH_HDR;
                    bad_d   = 1'b0;
                    csum_d  = 16'h0;
                end else if (i_data != 8'h55) begin
                    state_d = DROP;
                end
            end
            ETH_HDR: begin
                if (!i_rx_dv) begin
                    state_d = IDLE;
                end else begin
                    crc_d = crc_upd;
                    if (cnt_q == 11'd5 && win != i_my_mac && win != 48'hFFFF_FFFF_FFFF) bad_d = 1'b1;
                    if (cnt_q == 11'd11) mac_d = win;
                    if (cnt_q == 11'd13) begin
                        if (win[15:0] != 16'h0800) bad_d = 1'b1;
                        state_d = bad_d ? DROP : IP_HDR;
                    end
                end
            end
            IP_HDR: begin
                if (!i_rx_dv) begin
                    state_d = IDLE;
                end else begin
                    crc_d = crc_upd;
                    if (cnt_q[0]) csum_d = csum_fold;
                    if (cnt_q == 11'd0 && i_data != 8'h45) bad_d = 1'b1;
                    if (cnt_q == 11'd9 && i_data != 8'd17) bad_d = 1'b1;
                    if (cnt_q == 11'd15) ip_d = win[31:0];
                    if (cnt_q == 11'd19) begin
                        if (win[31:0] != i_my_ip || csum_fold != 16'hFFFF) bad_d = 1'b1;
                        state_d = bad_d ? DROP : UDP_HDR;
                    end
                end
            end
            UDP_HDR: begin
                if (!i_rx_dv) begin
                    state_d = IDLE;
                end else begin
                    crc_d = crc_upd;
                    if (cnt_q == 11'd1) port_d = win[15:0];
                    if (cnt_q == 11'd3 && win[15:0] != i_my_port) bad_d = 1'b1;
                    if (cnt_q == 11'd5) len_d = win[15:0];
                    if (cnt_q == 11'd7) begin
                        if (len_q < MIN_UDP_LEN || len_q > MAX_UDP_LEN) bad_d = 1'b1;
                        if (bad_d) begin
                            state_d = DROP;
                        end else begin
                            o_src_mac_d  = mac_q;
                            o_src_ip_d   = ip_q;
                            o_src_port_d = port_q;
                            o_data_len_d = len_q - MIN_UDP_LEN;
                            state_d      = (len_q == MIN_UDP_LEN) ? TAIL : PAYLOAD;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (!i_rx_dv) begin
                    // Truncated inside the payload: always a failing verdict.
                    state_d      = DONE;
                    o_pkt_done_d = 1'b1;
                    o_pkt_ok_d   = 1'b0;
                end else begin
                    crc_d       = crc_upd;
                    o_data_d    = i_data;
                    o_data_vl_d = 1'b1;
                    if (cnt_q == o_data_len_q[10:0] - 11'd1) state_d = TAIL;
                end
            end
            TAIL: begin
                if (!i_rx_dv) begin
                    state_d      = DONE;
                    o_pkt_done_d = 1'b1;
                    o_pkt_ok_d   = (crc_q == CRC_RESIDUE) && (cnt_q >= 11'd4);
                end else begin
                    crc_d = crc_upd;
                end
            end
            DROP: begin
                if (!i_rx_dv) state_d = IDLE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) cnt_d = 11'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 11'd0;
            sh_q         <= 40'h0;
            crc_q        <= CRC_INIT;
            csum_q       <= 16'h0;
            bad_q        <= 1'b0;
            mac_q        <= 48'h0;
            ip_q         <= 32'h0;
            port_q       <= 16'h0;
            len_q        <= 16'h0;
            o_data_q     <= 8'h0;
            o_data_vl_q  <= 1'b0;
            o_src_mac_q  <= 48'h0;
            o_src_ip_q   <= 32'h0;
            o_src_port_q <= 16'h0;
            o_data_len_q <= 16'h0;
            o_pkt_done_q <= 1'b0;
            o_pkt_ok_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sh_q         <= sh_d;
            crc_q        <= crc_d;
            csum_q       <= csum_d;
            bad_q        <= bad_d;
            mac_q        <= mac_d;
            ip_q         <= ip_d;
            port_q       <= port_d;
            len_q        <= len_d;
            o_data_q     <= o_data_d;
            o_data_vl_q  <= o_data_vl_d;
            o_src_mac_q  <= o_src_mac_d;
            o_src_ip_q   <= o_src_ip_d;
            o_src_port_q <= o_src_port_d;
            o_data_len_q <= o_data_len_d;
            o_pkt_done_q <= o_pkt_done_d;
            o_pkt_ok_q   <= o_pkt_ok_d;
        end
    end

    assign o_data     = o_data_q;
    assign o_data_vl  = o_data_vl_q;
    assign o_src_mac  = o_src_mac_q;
    assign o_src_ip   = o_src_ip_q;
    assign o_src_port = o_src_port_q;
    assign o_data_len = o_data_len_q;
    assign o_pkt_done = o_pkt_done_q;
    assign o_pkt_ok   = o_pkt_ok_q;
endmodule

// File: tb/tb_udp_recv.sv
// Bench for udp_recv: builds frames from field values, predicts the outcome from the
// filtering rules and compares strobes, header outputs and the end-of-frame verdict.
module tb_udp_recv;
    localparam logic [47:0] MY_MAC  = 48'h02_00_00_00_00_01;
    localparam logic [31:0] MY_IP   = 32'hC0A8010A;
    localparam logic [15:0] MY_PORT = 16'h1388;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_data = 8'h0;
    logic        i_rx_dv = 1'b0;
    logic [7:0]  o_data;
    logic        o_data_vl;
    logic [47:0] o_src_mac;
    logic [31:0] o_src_ip;
    logic [15:0] o_src_port;
    logic [15:0] o_data_len;
    logic        o_pkt_done;
    logic        o_pkt_ok;

    always #5 clk = ~clk;

    udp_recv dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_rx_dv(i_rx_dv),
        .i_my_mac(MY_MAC), .i_my_ip(MY_IP), .i_my_port(MY_PORT),
        .o_data(o_data), .o_data_vl(o_data_vl), .o_src_mac(o_src_mac),
        .o_src_ip(o_src_ip), .o_src_port(o_src_port), .o_data_len(o_data_len),
        .o_pkt_done(o_pkt_done), .o_pkt_ok(o_pkt_ok)
    );

    int n_checks = 0;
    int n_errors = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: collects every strobed byte, done pulses and header values seen at a first strobe.
    logic [7:0]  rx_q[$];
    int          done_cnt = 0;
    logic        last_ok = 1'b0;
    int unsigned done_cyc = 0;
    logic        prev_vl = 1'b0;
    logic [15:0] first_len = 16'h0;
    logic [15:0] first_port = 16'h0;
    always @(negedge clk) begin
        if (o_data_vl) begin
            rx_q.push_back(o_data);
            if (!prev_vl) begin
                first_len  = o_data_len;
                first_port = o_src_port;
            end
        end
        prev_vl = o_data_vl;
        if (o_pkt_done) begin
            done_cnt++;
            last_ok  = o_pkt_ok;
            done_cyc = cyc;
        end
    end

    // Frame description knobs
    logic [47:0] f_dst, f_smac;
    logic [15:0] f_type, f_cks_delta, f_dport, f_sport, f_len;
    logic [7:0]  f_b0, f_proto, f_fcs_xor;
    logic [31:0] f_dip, f_sip;
    logic        f_len_set, f_badpre;
    int          f_trunc;
    logic [7:0]  f_pay[$];
    logic [7:0]  frm[$];
    logic [15:0] ulen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic defaults();
        f_dst       = MY_MAC;
        f_smac      = {$urandom_range(0, 65535), $urandom} & 48'hFEFF_FFFF_FFFF;
        f_type      = 16'h0800;
        f_b0        = 8'h45;
        f_proto     = 8'd17;
        f_dip       = MY_IP;
        f_sip       = $urandom;
        f_cks_delta = 16'h0;
        f_dport     = MY_PORT;
        f_sport     = 16'($urandom);
        f_len_set   = 1'b0;
        f_len       = 16'h0;
        f_fcs_xor   = 8'h0;
        f_trunc     = -1;
        f_badpre    = 1'b0;
        f_pay.delete();
    endtask

    task automatic build();
        logic [7:0]  ip[20];
        logic [31:0] sum, crc;
        logic [15:0] cks, tot;
        ulen = f_len_set ? f_len : 16'(f_pay.size() + 8);
        tot  = ulen + 16'd20;
        ip = '{f_b0, 8'h00, tot[15:8], tot[7:0], 8'h12, 8'h34, 8'h40, 8'h00, 8'h40, f_proto,
               8'h00, 8'h00, f_sip[31:24], f_sip[23:16], f_sip[15:8], f_sip[7:0],
               f_dip[31:24], f_dip[23:16], f_dip[15:8], f_dip[7:0]};
        sum = 32'h0;
        for (int i = 0; i < 10; i++) sum = sum + {16'h0, ip[2*i], ip[2*i+1]};
        while (sum[31:16] != 16'h0) sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
        cks = ~sum[15:0] + f_cks_delta;
        ip[10] = cks[15:8];
        ip[11] = cks[7:0];
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(f_dst[8*(5-i) +: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(f_smac[8*(5-i) +: 8]);
        frm.push_back(f_type[15:8]); frm.push_back(f_type[7:0]);
        for (int i = 0; i < 20; i++) frm.push_back(ip[i]);
        frm.push_back(f_sport[15:8]); frm.push_back(f_sport[7:0]);
        frm.push_back(f_dport[15:8]); frm.push_back(f_dport[7:0]);
        frm.push_back(ulen[15:8]);    frm.push_back(ulen[7:0]);
        frm.push_back(8'h00);         frm.push_back(8'h00);
        foreach (f_pay[i]) frm.push_back(f_pay[i]);
        while (frm.size() < 60) frm.push_back(8'h00);
        // Standard Ethernet FCS: reflected CRC32, complemented, sent low byte first.
        crc = 32'hFFFFFFFF;
        foreach (frm[i]) begin
            crc = crc ^ {24'h0, frm[i]};
            for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
        end
        crc = ~crc;
        frm.push_back(crc[7:0]);
        frm.push_back(crc[15:8]);
        frm.push_back(crc[23:16]);
        frm.push_back(crc[31:24] ^ f_fcs_xor);
    endtask

    task automatic drive(input logic [7:0] b);
        @(posedge clk); #1;
        i_rx_dv = 1'b1;
        i_data  = b;
    endtask

    task automatic send_and_check(input string tag);
        int          n0, d0, nsend, exp_n;
        logic        exp_acc, exp_ok, pay_ok;
        int unsigned drop_cyc;
        build();
        exp_acc = (f_dst == MY_MAC || f_dst == 48'hFFFF_FFFF_FFFF) && f_type == 16'h0800 &&
                  f_b0 == 8'h45 && f_proto == 8'd17 && f_dip == MY_IP && f_cks_delta == 16'h0 &&
                  f_dport == MY_PORT && ulen >= 16'd8 && ulen <= 16'd1480 && !f_badpre;
        exp_n  = !exp_acc ? 0 : (f_trunc >= 0 ? f_trunc : f_pay.size());
        exp_ok = exp_acc && f_fcs_xor == 8'h0 && f_trunc < 0;
        n0 = rx_q.size();
        d0 = done_cnt;
        drive(f_badpre ? 8'hAA : 8'h55);
        for (int i = 0; i < 6; i++) drive(8'h55);
        drive(8'hD5);
        nsend = (f_trunc >= 0) ? 42 + f_trunc : frm.size();
        for (int i = 0; i < nsend; i++) drive(frm[i]);
        @(posedge clk); #1;
        i_rx_dv  = 1'b0;
        i_data   = 8'h00;
        drop_cyc = cyc;
        repeat (14) @(posedge clk);
        #1;
        chk({tag, " strobes"}, 64'(rx_q.size() - n0), 64'(exp_n));
        pay_ok = 1'b1;
        for (int i = 0; i < exp_n && n0 + i < rx_q.size(); i++)
            if (rx_q[n0+i] !== f_pay[i]) pay_ok = 1'b0;
        chk({tag, " payload"}, 64'(pay_ok), 64'(1));
        chk({tag, " done_cnt"}, 64'(done_cnt - d0), 64'(exp_acc));
        if (exp_acc) begin
            chk({tag, " pkt_ok"}, 64'(last_ok), 64'(exp_ok));
            chk({tag, " done_lat"}, 64'(done_cyc - drop_cyc), 64'(1));
            chk({tag, " src_mac"}, 64'(o_src_mac), 64'(f_smac));
            chk({tag, " src_ip"}, 64'(o_src_ip), 64'(f_sip));
            chk({tag, " src_port"}, 64'(o_src_port), 64'(f_sport));
            chk({tag, " data_len"}, 64'(o_data_len), 64'(ulen - 16'd8));
            if (exp_n > 0) begin
                chk({tag, " len_at_strobe"}, 64'(first_len), 64'(ulen - 16'd8));
                chk({tag, " port_at_strobe"}, 64'(first_port), 64'(f_sport));
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset data", 64'({o_data, o_data_vl}), 64'(0));
        chk("reset src", 64'(|{o_src_mac, o_src_ip, o_src_port}), 64'(0));
        chk("reset len", 64'(o_data_len), 64'(0));
        chk("reset done", 64'({o_pkt_done, o_pkt_ok}), 64'(0));
        rst = 1'b0;
        repeat (4) @(posedge clk);

        defaults(); f_pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF}; send_and_check("good");
        defaults(); f_pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF}; f_fcs_xor = 8'h01; send_and_check("bad_fcs");
        defaults(); f_pay = '{8'h11, 8'h22}; f_dport = 16'h1389; send_and_check("bad_port");
        defaults(); f_pay = '{8'h11, 8'h22}; f_b0 = 8'h46; send_and_check("bad_ihl");
        defaults(); f_pay = '{8'h11, 8'h22}; f_cks_delta = 16'h1; send_and_check("bad_cks");
        defaults(); f_pay = '{8'h01, 8'h02, 8'h03}; f_dst = 48'hFFFF_FFFF_FFFF; send_and_check("bcast");
        defaults(); f_pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF}; f_trunc = 2; send_and_check("trunc");
        defaults(); send_and_check("empty");
        defaults(); f_pay = '{8'h55}; f_badpre = 1'b1; send_and_check("bad_pre");
        defaults(); f_pay = '{8'h55}; f_type = 16'h86DD; send_and_check("bad_type");
        defaults(); f_pay = '{8'h55}; f_proto = 8'd6; send_and_check("bad_proto");
        defaults(); f_pay = '{8'h55}; f_dip = MY_IP ^ 32'h1; send_and_check("bad_dip");
        defaults(); f_len_set = 1'b1; f_len = 16'd1481; send_and_check("len_big");
        defaults(); f_len_set = 1'b1; f_len = 16'd7; send_and_check("len_small");

        // Reset in the middle of a payload, then a clean frame.
        defaults(); f_pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        build();
        for (int i = 0; i < 7; i++) drive(8'h55);
        drive(8'hD5);
        for (int i = 0; i < 44; i++) drive(frm[i]);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_mid data", 64'({o_data, o_data_vl}), 64'(0));
        chk("rst_mid src", 64'(|{o_src_mac, o_src_ip, o_src_port}), 64'(0));
        chk("rst_mid len", 64'(o_data_len), 64'(0));
        chk("rst_mid done", 64'({o_pkt_done, o_pkt_ok}), 64'(0));
        i_rx_dv = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) @(posedge clk);
        defaults(); f_pay = '{8'hCA, 8'hFE}; send_and_check("after_rst");

        for (int n = 0; n < 40; n++) begin
            int k, sz;
            defaults();
            sz = $urandom_range(0, 48);
            for (int i = 0; i < sz; i++) f_pay.push_back(8'($urandom));
            k = $urandom_range(0, 11);
            case (k)
                3:  f_dport = MY_PORT ^ 16'(1 << $urandom_range(0, 15));
                4:  f_dst = MY_MAC ^ 48'h0000_0000_0100;
                5:  f_proto = 8'd6;
                6:  f_cks_delta = 16'($urandom_range(1, 255));
                7:  f_fcs_xor = 8'($urandom_range(1, 255));
                8:  if (sz > 0) f_trunc = $urandom_range(0, sz - 1);
                9:  f_dst = 48'hFFFF_FFFF_FFFF;
                10: f_dip = MY_IP ^ 32'h0100;
                default: ;
            endcase
            send_and_check($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
